khazad_dec_key_reverser: RTL and testbench

Converts the KHAZAD encryption round-key sequence K^0..K^8 into the decryption sequence. Keys arrive from the key-schedule writer on a valid/ready stream and are buffered internally. The block then streams them out in reverse order to the round datapath, applying θ to the middle keys: K'^0 = K^8, K'^r = θ(K^(8−r)) for 1 ≤ r ≤ 7, and K'^8 = K^0. It sits between the key schedule and the shared encrypt/decrypt round core, and is the reading end of the round-key store that the schedule writes.

---
 rtl/khazad_pkg.sv | 45 ++++
 rtl/khazad_theta.sv | 22 ++
 rtl/khazad_dec_key_reverser.sv | 119 +++++++++++
 tb/tb_khazad_dec_key_reverser.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/khazad_pkg.sv
// KHAZAD shared definitions: round count, key width, GF(2^8) helpers, theta coefficients, FSM states.
// Latency: none (constants and pure combinational functions).
// Backpressure: not applicable.
package khazad_pkg;

   localparam int ROUNDS_DEF = 8;
   localparam int KEY_W_DEF  = 64;

   // Field polynomial x^8 + x^4 + x^3 + x^2 + 1.
   localparam logic [8:0] GF_POLY = 9'h11D;

   // First row of the theta matrix, h[0] in the top byte.
   localparam logic [63:0] H_COEF = 64'h0103040506080B07;

   typedef enum logic {
      LOAD = 1'b0,
      EMIT = 1'b1
   } state_e;

   // Multiply by x modulo GF_POLY.
   function automatic logic [7:0] gf_xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY[7:0] : 8'h00);
   endfunction

   // a * c over GF(2^8); c is normally a constant, so the unused xtime stages fold away.
   function automatic logic [7:0] gf_mul8(input logic [7:0] a, input logic [7:0] c);
      logic [7:0] acc;
      logic [7:0] pw;
      acc = 8'h00;
      pw  = a;
      for (int b = 0; b < 8; b++) begin
         if (c[b]) begin
            acc = acc ^ pw;
         end
         pw = gf_xtime(pw);
      end
      return acc;
   endfunction

   // h[idx], idx 0..7.
   function automatic logic [7:0] h_coef(input logic [2:0] idx);
      return H_COEF[{3'd7 - idx, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/khazad_theta.sv
// KHAZAD theta layer: 64-bit row vector times the involutional matrix H[i][j] = h[i^j].
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input.
module khazad_theta
   import khazad_pkg::*;
(
   input  logic [63:0] in_dat,
   output logic [63:0] out_dat
);

   // Output byte j is the XOR over input bytes i of in[i] * h[i^j]; byte 0 is the top byte.
   always_comb begin
      out_dat = '0;
      for (int j = 0; j < 8; j++) begin
         for (int i = 0; i < 8; i++) begin
            out_dat[8*(7-j) +: 8] = out_dat[8*(7-j) +: 8]
                                  ^ gf_mul8(in_dat[8*(7-i) +: 8], h_coef(3'(i ^ j)));
         end
      end
   end

endmodule

// File: rtl/khazad_dec_key_reverser.sv
// Buffers the ROUNDS+1 encryption round keys and replays them reversed, theta applied to the inner keys.
// Latency: first decryption key valid the cycle after the last key is accepted; one key per cycle after that.
// Backpressure: in_ready only in LOAD, out_valid only in EMIT; out_key/out_last hold while out_ready is low.
module khazad_dec_key_reverser
   import khazad_pkg::*;
#(
   parameter int ROUNDS = ROUNDS_DEF,
   parameter int KEY_W  = KEY_W_DEF   // theta is defined on 64-bit keys only
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [KEY_W-1:0] in_key,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [KEY_W-1:0] out_key,
   output logic             out_last,
   output logic             busy
);

   localparam int               IDX_W    = $clog2(ROUNDS + 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ROUNDS);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
   logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
   logic [KEY_W-1:0] mem_q [ROUNDS+1];
   logic [KEY_W-1:0] mem_d [ROUNDS+1];

   logic             in_fire;
   logic             out_fire;
   logic             rd_at_end;
   logic [KEY_W-1:0] sel_key;
   logic [KEY_W-1:0] theta_key;

   // Handshake enables are decoded straight from the state register, so they never glitch.
   assign in_ready  = (state_q == LOAD);
   assign out_valid = (state_q == EMIT);
   assign busy      = (state_q == EMIT);
   assign out_last  = (state_q == EMIT) && (rd_idx_q == '0);
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   // Key store write: the accepted key lands at the current write slot.
   always_comb begin
      for (int k = 0; k <= ROUNDS; k++) begin
         mem_d[k] = mem_q[k];
      end
      if (in_fire) begin
         mem_d[wr_idx_q] = in_key;
      end
   end

   // Next-state logic: fill slots 0..ROUNDS, then drain from ROUNDS down to 0.
   always_comb begin
      state_d  = state_q;
      wr_idx_d = wr_idx_q;
      rd_idx_d = rd_idx_q;
      case (state_q)
         LOAD: begin
            if (in_fire) begin
               if (wr_idx_q == IDX_LAST) begin
                  state_d  = EMIT;
                  wr_idx_d = '0;
                  rd_idx_d = IDX_LAST;
               end else begin
                  wr_idx_d = wr_idx_q + 1'b1;
               end
            end
         end
         EMIT: begin
            if (out_fire) begin
               if (rd_idx_q == '0) begin
                  state_d = LOAD;
               end else begin
                  rd_idx_d = rd_idx_q - 1'b1;
               end
            end
         end
         default: begin
            state_d = LOAD;
         end
      endcase
   end

   // Control registers; reset aborts any partial load or drain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= LOAD;
         wr_idx_q <= '0;
         rd_idx_q <= '0;
      end else begin
         state_q  <= state_d;
         wr_idx_q <= wr_idx_d;
         rd_idx_q <= rd_idx_d;
      end
   end

   // Key storage carries no reset; contents are only read after a full load.
   always_ff @(posedge clk) begin
      for (int k = 0; k <= ROUNDS; k++) begin
         mem_q[k] <= mem_d[k];
      end
   end

   khazad_theta u_theta (
      .in_dat  (sel_key),
      .out_dat (theta_key)
   );

   // Output mux: the outermost keys pass through untouched, the inner ones go through theta.
   always_comb begin
      sel_key   = mem_q[rd_idx_q];
      rd_at_end = (rd_idx_q == IDX_LAST) || (rd_idx_q == '0);
      out_key   = rd_at_end ? sel_key : theta_key;
   end

endmodule

// File: tb/tb_khazad_dec_key_reverser.sv
// Directed bench for the KHAZAD decryption key reverser; expected keys are hand-computed constants.
// Latency: checks first output the cycle after the ninth input and in_ready the cycle after the last output.
// Backpressure: exercises random out_ready stalls and keys offered while the block is emitting.
module tb_khazad_dec_key_reverser;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_key;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_key;
   logic        out_last;
   logic        busy;

   logic [63:0] inv_x, inv_y, inv_z;

   int checks = 0;
   int errors = 0;

   logic [63:0] set_a [9];
   logic [63:0] exp_a [9];
   logic [63:0] set_b [9];
   logic [63:0] exp_b [9];

   always #5 clk = ~clk;

   khazad_dec_key_reverser dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_key    (in_key),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_key   (out_key),
      .out_last  (out_last),
      .busy      (busy)
   );

   // Two chained theta instances for the involution property.
   khazad_theta u_t1 (.in_dat(inv_x), .out_dat(inv_y));
   khazad_theta u_t2 (.in_dat(inv_y), .out_dat(inv_z));

   task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
   task automatic load_set(input logic [63:0] keys [9], input int gap, input int count);
      for (int i = 0; i < count; i++) begin
         if (i != 0) begin
            for (int g = 0; g < gap; g++) begin
               in_valid = 1'b0;
               @(posedge clk); #1;
            end
         end
         chk1("load_in_ready", in_ready, 1'b1);
         chk1("load_out_valid", out_valid, 1'b0);
         in_valid = 1'b1;
         in_key   = keys[i];
         @(posedge clk); #1;
         in_valid = 1'b0;
      end
   endtask

   task automatic recv(input logic [63:0] exp, input logic exp_last, input bit rnd, input string tag);
      int stalls;
      stalls = 0;
      chk1({tag, "_valid"}, out_valid, 1'b1);
      chk1({tag, "_busy"}, busy, 1'b1);
      chk1({tag, "_in_ready"}, in_ready, 1'b0);
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      while (!out_ready) begin
         chk64({tag, "_stall_key"}, out_key, exp);
         chk1({tag, "_stall_last"}, out_last, exp_last);
         @(posedge clk); #1;
         chk1({tag, "_stall_valid"}, out_valid, 1'b1);
         stalls++;
         out_ready = (stalls >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      chk64({tag, "_key"}, out_key, exp);
      chk1({tag, "_last"}, out_last, exp_last);
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic emit_set(input logic [63:0] exp [9], input bit rnd, input string tag);
      for (int r = 0; r < 9; r++) begin
         recv(exp[r], (r == 8), rnd, $sformatf("%s_r%0d", tag, r));
      end
      chk1({tag, "_done_in_ready"}, in_ready, 1'b1);
      chk1({tag, "_done_out_valid"}, out_valid, 1'b0);
      chk1({tag, "_done_busy"}, busy, 1'b0);
   endtask

   task automatic check_emit_start(input string tag);
      chk1({tag, "_start_valid"}, out_valid, 1'b1);
      chk1({tag, "_start_in_ready"}, in_ready, 1'b0);
   endtask

   task automatic reset_now(input string tag);
      rst = 1'b1;
      #1;
      chk1({tag, "_in_ready"}, in_ready, 1'b1);
      chk1({tag, "_out_valid"}, out_valid, 1'b0);
      chk1({tag, "_busy"}, busy, 1'b0);
      chk1({tag, "_out_last"}, out_last, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      // Set A: constant-byte keys; theta leaves a constant-byte vector unchanged since XOR of h is 01.
      set_a = '{64'h1111111111111111, 64'h2222222222222222, 64'h3333333333333333,
                64'h4444444444444444, 64'h5555555555555555, 64'h6666666666666666,
                64'h7777777777777777, 64'h8888888888888888, 64'h9999999999999999};
      exp_a = '{64'h9999999999999999, 64'h8888888888888888, 64'h7777777777777777,
                64'h6666666666666666, 64'h5555555555555555, 64'h4444444444444444,
                64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111};
      // Set B: single-byte and structured keys with hand-derived theta images.
      set_b = '{64'hDEADBEEFCAFEF00D, 64'h0103040506080B07, 64'h0101010101010101,
                64'h8000000000000000, 64'h0000000000000001, 64'h0200000000000000,
                64'h0001000000000000, 64'h0100000000000000, 64'h0123456789ABCDEF};
      exp_b = '{64'h0123456789ABCDEF, 64'h0103040506080B07, 64'h030105040806070B,
                64'h0206080A0C10160E, 64'h070B080605040301, 64'h809D3ABA2774E9A7,
                64'h0101010101010101, 64'h0100000000000000, 64'hDEADBEEFCAFEF00D};

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_key    = '0;
      out_ready = 1'b0;
      inv_x     = '0;
      repeat (3) @(posedge clk);
      #1;
      chk1("reset_in_ready", in_ready, 1'b1);
      chk1("reset_out_valid", out_valid, 1'b0);
      chk1("reset_out_last", out_last, 1'b0);
      chk1("reset_busy", busy, 1'b0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Theta spot check and involution over random vectors.
      inv_x = 64'h0100000000000000;
      #1;
      chk64("theta_spot", inv_y, 64'h0103040506080B07);
      for (int n = 0; n < 1000; n++) begin
         inv_x = {$urandom, $urandom};
         #1;
         chk64("theta_involution", inv_z, inv_x);
      end
      @(posedge clk); #1;

      // Back-to-back load, always-ready drain.
      load_set(set_a, 0, 9);
      check_emit_start("seq_a");
      emit_set(exp_a, 1'b0, "seq_a");

      // Second set immediately after, random backpressure.
      load_set(set_b, 0, 9);
      check_emit_start("seq_b");
      emit_set(exp_b, 1'b1, "seq_b");

      // Gapped load, then keys offered while emitting must be refused.
      load_set(set_a, 3, 9);
      check_emit_start("gap_a");
      for (int c = 0; c < 3; c++) begin
         in_valid = 1'b1;
         in_key   = 64'hBADBADBADBADBAD0;
         chk1("emit_refuse_in_ready", in_ready, 1'b0);
         chk64("emit_hold_key", out_key, exp_a[0]);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      emit_set(exp_a, 1'b1, "gap_a");

      // Reset after four keys loaded, then a clean load.
      load_set(set_b, 0, 4);
      reset_now("rst_load");
      load_set(set_a, 0, 9);
      check_emit_start("after_rst_load");
      emit_set(exp_a, 1'b0, "after_rst_load");

      // Reset after three keys emitted, then a clean load.
      load_set(set_a, 0, 9);
      for (int r = 0; r < 3; r++) begin
         recv(exp_a[r], 1'b0, 1'b0, "pre_rst_emit");
      end
      reset_now("rst_emit");
      load_set(set_b, 0, 9);
      check_emit_start("after_rst_emit");
      emit_set(exp_b, 1'b1, "after_rst_emit");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
